// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the
// handshaked sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;
  localparam logic [3:0] OP_MOD = 4'hA;
  localparam logic [3:0] OP_EQ  = 4'hB;

  localparam int FLAG_N  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_C  = 5;
  localparam int FLAG_P  = 4;
  localparam int FLAG_I  = 3;
  localparam int FLAG_D  = 2;
  localparam int FLAG_V  = 1;
  localparam int FLAG_DZ = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per edge.
// hi/lo present the post-step values so the caller can latch them on the done edge.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step, lo_step;

  // Multiply: {hi,lo} holds {partial, multiplier}; divide: {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, m_q});
    if (is_div_q) begin
      hi_step = div_ge ? (div_sh[WIDTH-1:0] - m_q) : div_sh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    busy_d   = busy_q;
    is_div_d = is_div_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    if (start) begin
      busy_d   = 1'b1;
      is_div_d = is_div;
      m_d      = is_div ? b : a;
      hi_d     = '0;
      lo_d     = is_div ? a : b;
      cnt_d    = CW'(WIDTH - 1);
    end else if (busy_q) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign hi   = hi_step;
  assign lo   = lo_step;
  assign dz   = is_div_q && (m_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: IDLE accepts, BUSY runs the iterative engine, DONE holds
// registered result/flags until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       flags,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid/data until then, and ready never depends on valid.
  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [7:0]       flags_q, flags_d;

  logic             eng_start, eng_done, eng_dz;
  logic [WIDTH-1:0] eng_hi, eng_lo;

  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_c, fin_v, fin_dz;
  logic [7:0]       fin_flags;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .is_div ((op == OP_DIV) || (op == OP_MOD)),
    .a      (a),
    .b      (b),
    .done   (eng_done),
    .hi     (eng_hi),
    .lo     (eng_lo),
    .dz     (eng_dz)
  );

  always_comb begin
    add_s   = {1'b0, a} + {1'b0, b};
    sub_s   = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c   = add_s[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c   = sub_s[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: alu_res = '0;
    endcase
  end

  // The modulo opcode swaps the engine halves, except on divide-by-zero where
  // both divide and modulo report all-ones / dividend.
  always_comb begin
    fin_res = alu_res;
    fin_hi  = '0;
    fin_c   = alu_c;
    fin_v   = alu_v;
    fin_dz  = 1'b0;
    if (state_q == BUSY) begin
      fin_v  = 1'b0;
      fin_c  = 1'b0;
      fin_dz = eng_dz;
      case (op_q)
        OP_MUL: begin
          fin_res = eng_lo;
          fin_hi  = eng_hi;
          fin_c   = |eng_hi;
        end
        OP_MOD: begin
          fin_res = eng_dz ? eng_lo : eng_hi;
          fin_hi  = eng_dz ? eng_hi : eng_lo;
        end
        default: begin
          fin_res = eng_lo;
          fin_hi  = eng_hi;
        end
      endcase
    end
    fin_flags          = '0;
    fin_flags[FLAG_N]  = fin_res[WIDTH-1];
    fin_flags[FLAG_Z]  = (fin_res == '0);
    fin_flags[FLAG_C]  = fin_c;
    fin_flags[FLAG_P]  = ^fin_res;
    fin_flags[FLAG_I]  = 1'b0;
    fin_flags[FLAG_D]  = 1'b0;
    fin_flags[FLAG_V]  = fin_v;
    fin_flags[FLAG_DZ] = fin_dz;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_d     = res_q;
    hi_d      = hi_q;
    flags_d   = flags_q;
    eng_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (is_iter(op)) begin
            eng_start = 1'b1;
            state_d   = BUSY;
          end else begin
            res_d   = fin_res;
            hi_d    = fin_hi;
            flags_d = fin_flags;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (eng_done) begin
          res_d   = fin_res;
          hi_d    = fin_hi;
          flags_d = fin_flags;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = res_q;
  assign result_hi   = hi_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: single-cycle ops, iterative MUL/DIV/MOD,
// backpressure and asynchronous reset during BUSY.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] result, result_hi;
  logic [7:0]   flags;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .flags       (flags),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Drive one operation at a negedge while in_ready is high; returns #1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%b want 1", in_ready);
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 4'($urandom_range(0, 15));
  endtask

  // Counts edges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_out(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 50) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, result, result_hi, flags} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ov=%b res=%h hi=%h fl=%h want all 0", out_valid, result, result_hi, flags);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d want 0", dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub();
    int lat; bit bok;
    issue(OP_ADD, 8'h7F, 8'h01);
    wait_out(lat, bok);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL add_latency: got %0d want 0", lat); end
    checks++;
    if ({result, result_hi, flags} !== {8'h80, 8'h00, 8'h92}) begin
      errors++;
      $display("FAIL add_7f_01: res=%h hi=%h fl=%h want 80 00 92", result, result_hi, flags);
    end
    issue(OP_SUB, 8'h10, 8'h20);
    wait_out(lat, bok);
    checks++;
    if ({result, result_hi, flags} !== {8'hF0, 8'h00, 8'hA0}) begin
      errors++;
      $display("FAIL sub_10_20: res=%h hi=%h fl=%h want f0 00 a0", result, result_hi, flags);
    end
    issue(OP_SUB, 8'h80, 8'h01);
    wait_out(lat, bok);
    checks++;
    if ({result, result_hi, flags} !== {8'h7F, 8'h00, 8'h12}) begin
      errors++;
      $display("FAIL sub_80_01: res=%h hi=%h fl=%h want 7f 00 12", result, result_hi, flags);
    end
  endtask

  task automatic test_mul();
    int lat; bit bok;
    issue(OP_MUL, 8'hFF, 8'hFF);
    wait_out(lat, bok);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL mul_latency: got %0d want 8", lat); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL mul_busy_ready: in_ready seen high during BUSY"); end
    checks++;
    if ({result, result_hi, flags} !== {8'h01, 8'hFE, 8'h30}) begin
      errors++;
      $display("FAIL mul_ff_ff: res=%h hi=%h fl=%h want 01 fe 30", result, result_hi, flags);
    end
  endtask

  task automatic test_div();
    int lat; bit bok;
    issue(OP_DIV, 8'd200, 8'd7);
    wait_out(lat, bok);
    checks++;
    if ({result, result_hi, flags} !== {8'd28, 8'd4, 8'h10}) begin
      errors++;
      $display("FAIL div_200_7: res=%h hi=%h fl=%h want 1c 04 10", result, result_hi, flags);
    end
    issue(OP_MOD, 8'd200, 8'd7);
    wait_out(lat, bok);
    checks++;
    if ({result, result_hi, flags} !== {8'd4, 8'd28, 8'h10}) begin
      errors++;
      $display("FAIL mod_200_7: res=%h hi=%h fl=%h want 04 1c 10", result, result_hi, flags);
    end
    issue(OP_DIV, 8'd5, 8'd0);
    wait_out(lat, bok);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL divz_latency: got %0d want 8", lat); end
    checks++;
    if ({result, result_hi, flags} !== {8'hFF, 8'h05, 8'h81}) begin
      errors++;
      $display("FAIL div_5_0: res=%h hi=%h fl=%h want ff 05 81", result, result_hi, flags);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit bok;
    int bad_hold = 0;
    int phantom = 0;
    out_ready = 1'b0;
    issue(OP_EQ, 8'h3C, 8'h3C);
    wait_out(lat, bok);
    checks++;
    if ({result, flags} !== {8'h01, 8'h10}) begin
      errors++;
      $display("FAIL eq_3c: res=%h fl=%h want 01 10", result, flags);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || result !== 8'h01 || flags !== 8'h10 || in_ready !== 1'b0) bad_hold++;
    end
    checks++;
    if (bad_hold !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles unstable, want 0", bad_hold);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h01) begin
      errors++;
      $display("FAIL bp_release: ov=%b res=%h want 0 01", out_valid, result);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) phantom++;
    end
    checks++;
    if (phantom !== 0) begin
      errors++;
      $display("FAIL bp_no_accept: out_valid high %0d cycles want 0", phantom);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat; bit bok;
    int seen = 0;
    issue(OP_MUL, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, result_hi, flags} !== '0) begin
      errors++;
      $display("FAIL rst_busy_outputs: ov=%b res=%h hi=%h fl=%h want all 0", out_valid, result, result_hi, flags);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dbg_state !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_idle: state=%0d in_ready=%b want 0 1", dbg_state, in_ready);
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_busy_discard: out_valid high %0d cycles want 0", seen);
    end
    issue(OP_ADD, 8'd2, 8'd3);
    wait_out(lat, bok);
    checks++;
    if ({result, result_hi, flags} !== {8'd5, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL rst_busy_add: res=%h hi=%h fl=%h want 05 00 00", result, result_hi, flags);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res, hi;
    logic [7:0]   fl;
  } vec_t;

  task automatic test_back_to_back();
    vec_t v[10];
    int lat; bit bok;
    v[0] = '{OP_AND, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h40};
    v[1] = '{OP_OR,  8'hA0, 8'h05, 8'hA5, 8'h00, 8'h80};
    v[2] = '{OP_XOR, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'h80};
    v[3] = '{OP_NOT, 8'h0F, 8'h55, 8'hF0, 8'h00, 8'h80};
    v[4] = '{OP_SHL, 8'h81, 8'h00, 8'h02, 8'h00, 8'h30};
    v[5] = '{OP_SHR, 8'h81, 8'h00, 8'h40, 8'h00, 8'h30};
    v[6] = '{4'hC,   8'hFF, 8'hFF, 8'h00, 8'h00, 8'h40};
    v[7] = '{4'hF,   8'h12, 8'h34, 8'h00, 8'h00, 8'h40};
    v[8] = '{OP_EQ,  8'h01, 8'h02, 8'h00, 8'h00, 8'h40};
    v[9] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h60};
    for (int i = 0; i < 10; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_out(lat, bok);
      checks++;
      if (lat !== 0 || {result, result_hi, flags} !== {v[i].res, v[i].hi, v[i].fl}) begin
        errors++;
        $display("FAIL b2b_%0d op=%h: lat=%0d res=%h hi=%h fl=%h want lat 0 %h %h %h",
                 i, v[i].op, lat, result, result_hi, flags, v[i].res, v[i].hi, v[i].fl);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle_%0d: ov=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. Same opcode set and flag layout, generalised to `WIDTH` bits. MUL, DIV and MOD run as iterative multi-cycle operations producing a full double-width result. Sits between the decode stage and register writeback, with valid/ready on both sides so the issuing stage stalls while an iterative operation runs.

## Interface

- `WIDTH`, 8: operand/result width; must be ≥ 4.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands and opcode valid.
- `in_ready`  out  1: block can accept an operation.
- `a`, `b`  in  WIDTH: operands (unsigned unless noted).
- `op`  in  4: opcode.
- `out_valid`  out  1: result and flags valid.
- `out_ready`  in  1: consumer takes the result.
- `result`  out  WIDTH: primary result.
- `result_hi`  out  WIDTH: secondary result.
  - MUL: upper product half.
  - DIV: remainder.
  - MOD: quotient.
  - All other ops: 0.
- `flags`  out  8: bit layout, MSB to LSB:
  - `[7]` N: result MSB.
  - `[6]` Z: result equals 0.
  - `[5]` C: carry; see Operation.
  - `[4]` P: XOR of all result bits.
  - `[3]` I: reserved, 0.
  - `[2]` D: reserved, 0.
  - `[1]` V: signed overflow.
  - `[0]` DZ: divide by zero.

## Operation

- Opcodes:
  - 0000 ADD.
  - 0001 SUB.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT a.
  - 0110 SHL a by 1.
  - 0111 SHR a by 1 (logical).
  - 1000 MUL.
  - 1001 DIV.
  - 1010 MOD.
  - 1011 EQ: result 1 if a == b, else 0.
  - 1100–1111 NOP: result 0.
- The operation is accepted on a rising edge with `in_valid && in_ready`. Operands and opcode are captured and need not be held afterwards.
- FSM states:
  - IDLE: `in_ready` = 1. On accept, single-cycle ops go to DONE; MUL/DIV/MOD go to BUSY.
  - BUSY: iterative engine runs exactly `WIDTH` edges, then goes to DONE.
  - DONE: `out_valid` = 1. Goes to IDLE on an edge with `out_ready` = 1.
- `in_ready` is high only in IDLE, so accept and deliver never overlap.
- C flag by op:
  - ADD: carry out of bit `WIDTH-1`.
  - SUB: borrow, i.e. a < b.
  - SHL: old `a[WIDTH-1]`.
  - SHR: old `a[0]`.
  - MUL: `result_hi` ≠ 0.
  - All other ops: 0.
- V flag (two's complement):
  - ADD: operands have equal signs and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
  - All other ops: 0.
- MUL: shift-add, one partial product per edge; the full 2·`WIDTH` product goes to {`result_hi`, `result`}.
- DIV/MOD: restoring division, one quotient bit per edge.
- Divide by zero (b = 0):
  - DIV/MOD still take `WIDTH` BUSY edges so latency does not depend on data.
  - `result` = all ones, `result_hi` = a, DZ = 1.
  - N/Z/P are computed from `result`.
- N, Z and P are always computed from the final `result`, never from `result_hi`.
- `result`, `result_hi` and `flags` are registered. They are stable from DONE entry until DONE exit and keep their values in IDLE until the next DONE.

## Timing

- Reset (`rst_n` low, asynchronous, any state including mid-BUSY):
  - State goes to IDLE.
  - `in_ready` = 1 once reset is released.
  - `out_valid` = 0; `result`, `result_hi`, `flags` = 0.
  - The iteration counter is cleared.
  - A partially computed MUL/DIV is discarded with no output.
- Single-cycle op accepted at edge E0: `out_valid` is high after E0, so latency is 1.
- Iterative op accepted at E0:
  - BUSY after E0.
  - Counter is loaded with `WIDTH-1` at E0 and decrements each BUSY edge.
  - The edge at which the counter equals 0 enters DONE, so `out_valid` is high after E0+`WIDTH`.
- With `out_ready` held high, throughput is one op per 2 cycles for single-cycle ops and per `WIDTH`+2 cycles for iterative ops. DONE and IDLE each take one cycle.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.

## Structure

- Package `alu_pkg`:
  - opcode localparams.
  - flag bit index constants (`FLAG_N` … `FLAG_DZ`).
  - FSM state enum {IDLE, BUSY, DONE}.
- Sub-module `alu_muldiv_iter`, parametrised by `WIDTH`:
  - `start`, `is_div`, a, b in.
  - `done`, `hi`, `lo`, `dz` out.
  - owns the counter and the shift registers.
- Top level holds the FSM, the single-cycle datapath, flag generation and output registers.

## Test plan

All scenarios use `WIDTH`=8.

- ADD a=0x7F, b=0x01 → 1 cycle later `result`=0x80, N=1, Z=0, C=0, P=1, V=1.
- SUB a=0x10, b=0x20 → `result`=0xF0, C=1, N=1, V=0; SUB 0x80−0x01 → `result`=0x7F, V=1.
- MUL a=0xFF, b=0xFF → `out_valid` exactly 8 cycles after accept; `result_hi`=0xFE, `result`=0x01, C=1; `in_ready`=0 throughout BUSY.
- DIV a=200, b=7 → `result`=28, `result_hi`=4. DIV a=5, b=0 → `result`=0xFF, `result_hi`=5, DZ=1, same 8-cycle latency.
- Backpressure: EQ a=b=0x3C with `out_ready` held 0 for 5 cycles → `out_valid` and `result`=0x01 stay stable; `in_valid` pulses during that time are not accepted.
- Reset asserted at BUSY cycle 4 of a MUL → outputs 0 immediately, IDLE after release, no `out_valid`; a following ADD 2+3 returns 5.
